// File: rtl/dcache_wt_pkg.sv
// Shared constants and FSM encoding for the write-through data cache.
// Field widths are derived from the line-count and line-size exponents.
package dcache_wt_pkg;

  localparam int DEF_INDEX_BITS  = 6;
  localparam int DEF_OFFSET_BITS = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Word-addressed CPU space is 30 bits; whatever index/offset do not use is tag.
  function automatic int tag_bits(input int index_bits, input int offset_bits);
    return 30 - index_bits - offset_bits;
  endfunction

endpackage

// File: rtl/dcache_wt_if.sv
// Core data-port and backing-memory signals of the write-through data cache.
// slave is the cache's view; master is the core/memory side driving it.
interface dcache_wt_if;

  logic [31:0] i_addr;
  logic [3:0]  i_we;
  logic        i_rd;
  logic [31:0] i_data;
  logic [31:0] o_data;
  logic        o_valid;
  logic [31:0] o_mem_addr;
  logic        o_mem_rd;
  logic [3:0]  o_mem_we;
  logic [31:0] o_mem_data;
  logic [31:0] i_mem_data;
  logic        i_mem_ack;

  modport slave (
    input  i_addr, i_we, i_rd, i_data, i_mem_data, i_mem_ack,
    output o_data, o_valid, o_mem_addr, o_mem_rd, o_mem_we, o_mem_data
  );

  modport master (
    output i_addr, i_we, i_rd, i_data, i_mem_data, i_mem_ack,
    input  o_data, o_valid, o_mem_addr, o_mem_rd, o_mem_we, o_mem_data
  );

endinterface

// File: rtl/dcache_wt_ram.sv
// Word-wide data array with asynchronous read and byte-enabled synchronous write.
// Not reset; validity is tracked by the owner of the array.
module dcache_wt_ram #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 i_clk,
  input  logic [3:0]           i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [31:0]          i_wdata,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [31:0]          o_rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) begin
        mem_q[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with a word-wide
// refill/write-through port. Read hits complete in the request cycle.
//
// state  | meaning
// IDLE   | serve read hits; launch a line refill or a write-through
// REFILL | fetch the line word by word, line becomes valid on the last ack
// WRITE  | write-through in flight; on ack a hit patches the cached bytes
// DONE   | one-cycle completion of a write
module dcache_wt
  import dcache_wt_pkg::*;
#(
  parameter int INDEX_BITS  = DEF_INDEX_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic       i_clk,
  input  logic       i_rst,
  dcache_wt_if.slave bus
);

  localparam int TAG_BITS = tag_bits(INDEX_BITS, OFFSET_BITS);
  localparam int LINES    = 1 << INDEX_BITS;

  state_e                 state_q;
  logic [OFFSET_BITS-1:0] cnt_q;
  logic [OFFSET_BITS-1:0] cnt_d;
  logic [LINES-1:0]       valid_q;
  logic [TAG_BITS-1:0]    tag_q [LINES];
  logic                   mem_rd_q;
  logic [3:0]             mem_we_q;
  logic [31:0]            mem_addr_q;
  logic [31:0]            mem_data_q;

  logic [OFFSET_BITS-1:0] offset;
  logic [INDEX_BITS-1:0]  index;
  logic [TAG_BITS-1:0]    tag;
  logic                   wr_req;
  logic                   rd_req;
  logic                   hit;
  logic                   last_beat;
  logic                   fill_ack;
  logic                   patch_ack;
  logic [3:0]             ram_we;
  logic [INDEX_BITS+OFFSET_BITS-1:0] ram_waddr;
  logic [31:0]            ram_wdata;
  logic [31:0]            ram_rdata;
  logic                   valid_c;
  logic [31:0]            data_c;
  logic                   unused_addr_lsbs;

  assign offset           = bus.i_addr[OFFSET_BITS+1:2];
  assign index            = bus.i_addr[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
  assign tag              = bus.i_addr[31:INDEX_BITS+OFFSET_BITS+2];
  assign unused_addr_lsbs = ^bus.i_addr[1:0];

  assign wr_req    = |bus.i_we;
  assign rd_req    = bus.i_rd && !wr_req;
  assign hit       = valid_q[index] && (tag_q[index] == tag);
  assign last_beat = &cnt_q;
  assign cnt_d     = cnt_q + OFFSET_BITS'(1);

  // Request inputs are held by the core while stalled, so they are used live.
  assign fill_ack  = (state_q == S_REFILL) && bus.i_mem_ack && !i_rst;
  assign patch_ack = (state_q == S_WRITE) && bus.i_mem_ack && hit && !i_rst;

  always_comb begin
    ram_we    = 4'h0;
    ram_waddr = {index, offset};
    ram_wdata = bus.i_data;
    if (fill_ack) begin
      ram_we    = 4'hF;
      ram_waddr = {index, cnt_q};
      ram_wdata = bus.i_mem_data;
    end else if (patch_ack) begin
      ram_we = bus.i_we;
    end
  end

  dcache_wt_ram #(
    .ADDR_BITS(INDEX_BITS + OFFSET_BITS)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (ram_we),
    .i_waddr(ram_waddr),
    .i_wdata(ram_wdata),
    .i_raddr({index, offset}),
    .o_rdata(ram_rdata)
  );

  always_comb begin
    valid_c = 1'b0;
    data_c  = '0;
    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          valid_c = hit;
          if (hit) data_c = ram_rdata;
        end else begin
          valid_c = !wr_req;
        end
      end
      S_DONE:  valid_c = 1'b1;
      default: valid_c = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      valid_q    <= '0;
      mem_rd_q   <= 1'b0;
      mem_we_q   <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_req) begin
            state_q    <= S_WRITE;
            mem_we_q   <= bus.i_we;
            mem_addr_q <= {bus.i_addr[31:2], 2'b00};
            mem_data_q <= bus.i_data;
          end else if (rd_req && !hit) begin
            state_q    <= S_REFILL;
            cnt_q      <= '0;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= {tag, index, {OFFSET_BITS{1'b0}}, 2'b00};
          end
        end
        S_REFILL: begin
          if (bus.i_mem_ack) begin
            cnt_q      <= cnt_d;
            mem_addr_q <= {tag, index, cnt_d, 2'b00};
            if (last_beat) begin
              valid_q[index] <= 1'b1;
              state_q        <= S_IDLE;
              mem_rd_q       <= 1'b0;
              mem_addr_q     <= '0;
            end
          end
        end
        S_WRITE: begin
          if (bus.i_mem_ack) begin
            state_q    <= S_DONE;
            mem_we_q   <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tags are only meaningful behind a set valid bit, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (fill_ack && last_beat) begin
      tag_q[index] <= tag;
    end
  end

  assign bus.o_valid    = valid_c;
  assign bus.o_data     = data_c;
  assign bus.o_mem_rd   = mem_rd_q;
  assign bus.o_mem_we   = mem_we_q;
  assign bus.o_mem_addr = mem_addr_q;
  assign bus.o_mem_data = mem_data_q;

endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt: directed scenarios plus randomized traffic
// against a line-level reference model and a word-addressed memory model.
module tb_dcache_wt;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_wt_if bus ();

  dcache_wt dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit [31:0] mem_m [bit [31:0]];
  bit        line_v [int];
  bit [31:0] line_base [int];

  int        resp_fixed = -1;
  int        resp_max   = 2;
  int        resp_left  = -1;
  int        resp_cycles;
  int        rd_beats;
  int        wr_beats;
  bit [31:0] beat_q [$];
  bit [31:0] wr_addr_seen;
  bit [31:0] wr_data_seen;
  bit [3:0]  wr_we_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] mem_rd(input bit [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Backing memory: acks each request after a chosen number of wait cycles.
  initial begin : responder
    bit [31:0] m;
    bus.i_mem_ack  = 1'b0;
    bus.i_mem_data = '0;
    forever begin
      @(negedge clk);
      bus.i_mem_ack = 1'b0;
      if (rst) begin
        resp_left = -1;
      end else if (bus.o_mem_rd || (bus.o_mem_we != 4'h0)) begin
        resp_cycles++;
        if (resp_left < 0)
          resp_left = (resp_fixed >= 0) ? resp_fixed : int'($urandom_range(0, resp_max));
        if (resp_left == 0) begin
          bus.i_mem_ack = 1'b1;
          resp_left = -1;
          if (bus.o_mem_rd) begin
            bus.i_mem_data = mem_rd(bus.o_mem_addr);
            beat_q.push_back(bus.o_mem_addr);
            rd_beats++;
          end else begin
            m = {{8{bus.o_mem_we[3]}}, {8{bus.o_mem_we[2]}},
                 {8{bus.o_mem_we[1]}}, {8{bus.o_mem_we[0]}}};
            mem_m[bus.o_mem_addr] = (mem_rd(bus.o_mem_addr) & ~m) | (bus.o_mem_data & m);
            wr_addr_seen = bus.o_mem_addr;
            wr_data_seen = bus.o_mem_data;
            wr_we_seen   = bus.o_mem_we;
            wr_beats++;
          end
        end else begin
          resp_left--;
        end
      end
    end
  end

  // One CPU access, called and returning at negedge+1 with the cache idle.
  task automatic do_op(input string name, input bit [31:0] addr, input bit [3:0] we,
                       input bit rd, input bit [31:0] wdata, output bit [31:0] got);
    int        idx;
    bit [31:0] base;
    bit        is_wr;
    bit        is_rd;
    bit        hit;
    int        cycles;
    bit [31:0] exp_data;
    idx      = int'((addr >> 4) % 64);
    base     = addr >> 4;
    is_wr    = (we != 4'h0);
    is_rd    = rd && !is_wr;
    hit      = line_v.exists(idx) && line_v[idx] && (line_base[idx] == base);
    exp_data = is_rd ? mem_rd({addr[31:2], 2'b00}) : 32'h0;
    resp_cycles = 0;
    rd_beats    = 0;
    wr_beats    = 0;
    beat_q.delete();
    bus.i_addr = addr;
    bus.i_we   = we;
    bus.i_rd   = rd;
    bus.i_data = wdata;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.o_valid && cycles < 200);
    got = bus.o_data;
    check({name, " valid"}, 32'(bus.o_valid), 32'd1);
    check({name, " data"}, bus.o_data, exp_data);
    check({name, " cycles"}, 32'(cycles), 32'(1 + resp_cycles));
    check({name, " rd_beats"}, 32'(rd_beats), (is_rd && !hit) ? 32'd4 : 32'd0);
    check({name, " wr_beats"}, 32'(wr_beats), is_wr ? 32'd1 : 32'd0);
    if (is_rd && !hit && beat_q.size() == 4) begin
      for (int i = 0; i < 4; i++)
        check({name, " beat_addr"}, beat_q[i], {base, 4'h0} + 32'(4 * i));
    end
    if (is_wr && wr_beats == 1) begin
      check({name, " wr_addr"}, wr_addr_seen, {addr[31:2], 2'b00});
      check({name, " wr_we"}, 32'(wr_we_seen), 32'(we));
      check({name, " wr_data"}, wr_data_seen, wdata);
    end
    if (is_rd && !hit) begin
      line_v[idx]    = 1'b1;
      line_base[idx] = base;
    end
    #1;
    bus.i_we = 4'h0;
    bus.i_rd = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin : main
    bit [31:0] got;
    bit [31:0] a;
    bit [3:0]  we;
    int        cycles;
    rst        = 1'b1;
    bus.i_addr = '0;
    bus.i_we   = '0;
    bus.i_rd   = 1'b0;
    bus.i_data = '0;
    mem_m[32'h1000] = 32'h0000_00A0;
    mem_m[32'h1004] = 32'h0000_00A1;
    mem_m[32'h1008] = 32'h0000_00A2;
    mem_m[32'h100C] = 32'h0000_00A3;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst valid", 32'(bus.o_valid), 32'd1);
    check("rst data", bus.o_data, 32'h0);
    check("rst mem_rd", 32'(bus.o_mem_rd), 32'd0);
    check("rst mem_we", 32'(bus.o_mem_we), 32'd0);
    check("rst mem_addr", bus.o_mem_addr, 32'h0);
    check("rst mem_data", bus.o_mem_data, 32'h0);
    #1;

    resp_fixed = -1;
    do_op("rd_miss_1004", 32'h0000_1004, 4'h0, 1'b1, 32'h0, got);
    check("rd_miss_1004 const", got, 32'h0000_00A1);
    do_op("rd_hit_100c", 32'h0000_100C, 4'h0, 1'b1, 32'h0, got);
    check("rd_hit_100c const", got, 32'h0000_00A3);

    resp_fixed = 3;
    do_op("wr_hit_1004", 32'h0000_1004, 4'b0010, 1'b0, 32'h0000_BB00, got);
    resp_fixed = -1;
    do_op("rd_after_wr", 32'h0000_1004, 4'h0, 1'b1, 32'h0, got);
    check("rd_after_wr const", got, 32'h0000_BBA1);

    do_op("wr_miss_2000", 32'h0000_2000, 4'hF, 1'b0, 32'hDEAD_BEEF, got);
    do_op("rd_2000_noalloc", 32'h0000_2000, 4'h0, 1'b1, 32'h0, got);
    check("rd_2000 const", got, 32'hDEAD_BEEF);

    do_op("conf_rd_1000", 32'h0000_1000, 4'h0, 1'b1, 32'h0, got);
    do_op("conf_rd_1400", 32'h0000_1400, 4'h0, 1'b1, 32'h0, got);
    do_op("conf_rd_1000b", 32'h0000_1000, 4'h0, 1'b1, 32'h0, got);
    do_op("no_req", 32'h0000_1000, 4'h0, 1'b0, 32'h1234_5678, got);
    do_op("wr_and_rd", 32'h0000_1008, 4'b1001, 1'b1, 32'h7700_0055, got);

    // Reset lands on the cycle of the second refill beat.
    resp_fixed  = 0;
    rd_beats    = 0;
    resp_cycles = 0;
    beat_q.delete();
    bus.i_addr = 32'h0000_3008;
    bus.i_rd   = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      #1;
      cycles++;
    end while (!(bus.i_mem_ack && rd_beats == 2) && cycles < 50);
    check("rst_mid beat2", 32'(rd_beats), 32'd2);
    rst      = 1'b1;
    bus.i_rd = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid mem_rd", 32'(bus.o_mem_rd), 32'd0);
    check("rst_mid valid", 32'(bus.o_valid), 32'd1);
    check("rst_mid mem_addr", bus.o_mem_addr, 32'h0);
    rst = 1'b0;
    line_v.delete();
    resp_fixed = -1;
    do_op("rd_after_rst", 32'h0000_3008, 4'h0, 1'b1, 32'h0, got);

    for (int n = 0; n < 250; n++) begin
      a = 32'h0004_0000 | (32'($urandom_range(0, 3)) << 10) |
          (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
      we = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : 4'h0;
      do_op("rand", a, we, ($urandom_range(0, 9) != 0), $urandom, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
